// File: rtl/fib_bcd_conv.sv
// Sequential double-dabble converter: one unsigned binary sample in, packed BCD
// plus significant-digit count out, one bit per clock, valid/ready on both sides.
module fib_bcd_conv #(
   parameter int WIDTH  = 32,
   parameter int DIGITS = 10
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [WIDTH-1:0]      bin_in,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [4*DIGITS-1:0]   bcd_out,
   output logic [3:0]            num_digits,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [1:0]            state_dbg
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam int BW = 4 * DIGITS;

   // Handshake rule on both ports: a transfer happens on a rising edge where
   // valid and ready are both high; in_ready is high only in IDLE, out_valid
   // only in DONE, so intake and output never overlap.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [WIDTH-1:0]  bin_q, bin_step;
   logic [BW-1:0]     bcd_q, bcd_adj, bcd_step;
   logic [CW-1:0]     cnt_q;
   logic [3:0]        nd_step;
   logic              last_step;

   assign state_dbg = state_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      last_step = (cnt_q == CW'(WIDTH - 1));
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_d = SHIFT;
         end
         SHIFT: begin
            if (last_step) state_d = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // One double-dabble step: add 3 to every digit >= 5, then shift {bcd, bin} left.
   always_comb begin
      bcd_adj = bcd_q;
      for (int i = 0; i < DIGITS; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
      bcd_step = {bcd_adj[BW-2:0], bin_q[WIDTH-1]};
      bin_step = {bin_q[WIDTH-2:0], 1'b0};
   end

   // Significant digits of the final step's result; all-zero reports one digit.
   always_comb begin
      nd_step = 4'd1;
      for (int i = 0; i < DIGITS; i++) begin
         if (bcd_step[4*i +: 4] != 4'd0) nd_step = 4'(i + 1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bin_q      <= '0;
         bcd_q      <= '0;
         cnt_q      <= '0;
         bcd_out    <= '0;
         num_digits <= 4'd1;
      end else begin
         if (state_q == IDLE && in_valid) begin
            bin_q <= bin_in;
            bcd_q <= '0;
            cnt_q <= '0;
         end else if (state_q == SHIFT) begin
            bin_q <= bin_step;
            bcd_q <= bcd_step;
            cnt_q <= cnt_q + CW'(1);
            // Visible result only changes here, so partial values never leak out.
            if (last_step) begin
               bcd_out    <= bcd_step;
               num_digits <= nd_step;
            end
         end
      end
   end

endmodule

// File: tb/tb_fib_bcd_conv.sv
// Directed bench for fib_bcd_conv: hand-computed BCD results, latency,
// backpressure, busy-input rejection and asynchronous reset mid-conversion.
module tb_fib_bcd_conv;

   logic        clk;
   logic        reset;
   logic [31:0] bin_in;
   logic        in_valid;
   logic        in_ready;
   logic [39:0] bcd_out;
   logic [3:0]  num_digits;
   logic        out_valid;
   logic        out_ready;
   logic [1:0]  state_dbg;

   int n_checks = 0;
   int n_errors = 0;
   logic [39:0] last_bcd = '0;
   logic [63:0] exp_q[$];

   fib_bcd_conv #(.WIDTH(32), .DIGITS(10)) dut (
      .clk        (clk),
      .reset      (reset),
      .bin_in     (bin_in),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .bcd_out    (bcd_out),
      .num_digits (num_digits),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .state_dbg  (state_dbg)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge. Accepts val, watches the shift phase, checks the
   // result, holds backpressure for hold cycles, then completes the handshake.
   task automatic convert(input logic [31:0] val, input logic [39:0] exp_bcd,
                          input logic [3:0] exp_nd, input int hold, input bit poke);
      int  k;
      bit  changed;
      bin_in   = val;
      in_valid = 1'b1;
      check("in_ready_idle", 64'(in_ready), 64'd1);
      @(negedge clk);
      in_valid = 1'b0;
      check("in_ready_busy", 64'(in_ready), 64'd0);
      k = 0;
      changed = 1'b0;
      while (!out_valid && k < 100) begin
         if (bcd_out !== last_bcd) changed = 1'b1;
         in_valid = poke && k >= 2 && k < 6;
         if (poke) bin_in = 32'd99999;
         @(negedge clk);
         k++;
      end
      in_valid = 1'b0;
      check("latency", 64'(k), 64'd32);
      check("no_partial", 64'(changed), 64'd0);
      exp_q.push_back(64'(exp_bcd));
      check("bcd_out", 64'(bcd_out), exp_q.pop_front());
      check("num_digits", 64'(num_digits), 64'(exp_nd));
      last_bcd = exp_bcd;
      for (int h = 0; h < hold; h++) begin
         in_valid = (h < hold / 2);
         bin_in   = 32'd42;
         @(negedge clk);
         check("hold_valid", 64'(out_valid), 64'd1);
         check("hold_bcd", 64'(bcd_out), 64'(exp_bcd));
         check("hold_nd", 64'(num_digits), 64'(exp_nd));
         check("hold_in_ready", 64'(in_ready), 64'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("post_hs_valid", 64'(out_valid), 64'd0);
      check("post_hs_ready", 64'(in_ready), 64'd1);
      check("post_hs_bcd", 64'(bcd_out), 64'(exp_bcd));
   endtask

   logic [31:0] fib_v [14] = '{32'd1, 32'd2, 32'd3, 32'd5, 32'd8, 32'd13, 32'd21,
                               32'd34, 32'd55, 32'd89, 32'd144, 32'd233, 32'd377, 32'd832040};
   logic [39:0] fib_b [14] = '{40'h1, 40'h2, 40'h3, 40'h5, 40'h8, 40'h13, 40'h21,
                               40'h34, 40'h55, 40'h89, 40'h144, 40'h233, 40'h377, 40'h832040};
   logic [3:0]  fib_n [14] = '{4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd2, 4'd2,
                               4'd2, 4'd2, 4'd2, 4'd3, 4'd3, 4'd3, 4'd6};

   initial begin
      reset     = 1'b0;
      bin_in    = '0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_bcd", 64'(bcd_out), 64'd0);
      check("rst_nd", 64'(num_digits), 64'd1);
      check("rst_state", 64'(state_dbg), 64'd0);

      convert(32'd0, 40'h0, 4'd1, 0, 1'b0);
      convert(32'hFFFFFFFF, 40'h4294967295, 4'd10, 0, 1'b0);
      for (int i = 0; i < 14; i++) convert(fib_v[i], fib_b[i], fib_n[i], 0, 1'b0);
      convert(32'd1836311903, 40'h1836311903, 4'd10, 10, 1'b0);
      convert(32'd12345, 40'h12345, 4'd5, 0, 1'b1);

      // Asynchronous reset between edges, ten steps into the shift phase.
      bin_in   = 32'd5;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (10) @(negedge clk);
      #2 reset = 1'b0;
      #1;
      check("abort_out_valid", 64'(out_valid), 64'd0);
      check("abort_in_ready", 64'(in_ready), 64'd1);
      check("abort_bcd", 64'(bcd_out), 64'd0);
      check("abort_nd", 64'(num_digits), 64'd1);
      @(negedge clk);
      reset    = 1'b1;
      last_bcd = '0;
      convert(32'd7, 40'h7, 4'd1, 0, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
